// File: rtl/rgb_mode_sequencer.sv
// rtl/rgb_mode_sequencer.sv - key-driven RGB LED mode controller with colour stepping and breath setup
module rgb_mode_sequencer #(
  parameter int TICK_DIV    = 12000,
  parameter int DWELL_UNIT  = 100,
  parameter int BREATH_BASE = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_pulse,
  input  logic [3:0]  speed,
  output logic [2:0]  mode,
  output logic [2:0]  color0,
  output logic [2:0]  color1,
  output logic        breath_en,
  output logic [24:0] breath_cnt_num,
  output logic        step_pulse
);

  localparam logic [2:0] M_OFF    = 3'd0;
  localparam logic [2:0] M_SOLID  = 3'd1;
  localparam logic [2:0] M_BREATH = 3'd2;
  localparam logic [2:0] M_CYCLE  = 3'd3;
  localparam logic [2:0] M_ALT    = 3'd4;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Palette colours are active-low {B,G,R}
  function automatic logic [2:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    palette = 3'b110;
      3'd1:    palette = 3'b100;
      3'd2:    palette = 3'b101;
      3'd3:    palette = 3'b001;
      3'd4:    palette = 3'b011;
      3'd5:    palette = 3'b010;
      default: palette = 3'b111;
    endcase
  endfunction

  function automatic logic [2:0] next_mode(input logic [2:0] m);
    case (m)
      M_OFF:    next_mode = M_SOLID;
      M_SOLID:  next_mode = M_BREATH;
      M_BREATH: next_mode = M_CYCLE;
      M_CYCLE:  next_mode = M_ALT;
      default:  next_mode = M_OFF;
    endcase
  endfunction

  logic [2:0]    mode_q, mode_d;
  logic [2:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   dwell_q, dwell_d;
  logic [3:0]    spd_q, spd_d;
  logic          first_q;
  logic          step_q, step_d;
  logic [2:0]    color0_q, color0_d;
  logic [2:0]    color1_q, color1_d;
  logic          breath_en_q, breath_en_d;
  logic [24:0]   breath_cnt_q, breath_cnt_d;

  logic [3:0]    spd_eff;
  logic [15:0]   dwell_len;
  logic          running;
  logic          tick;
  logic          step;
  logic [2:0]    idx_next;

  assign spd_eff   = (speed == 4'd0) ? 4'd1 : speed;
  assign dwell_len = 16'(spd_q) * 16'(DWELL_UNIT);
  assign running   = (mode_q == M_CYCLE) || (mode_q == M_ALT);
  assign tick      = running && (presc_q == PRESC_LAST);
  assign step      = tick && (dwell_q == dwell_len - 16'd1);
  assign idx_next  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

  // State and registered outputs; first_q lets speed be sampled on the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= M_OFF;
      idx_q        <= 3'd0;
      phase_q      <= 1'b0;
      presc_q      <= '0;
      dwell_q      <= 16'd0;
      spd_q        <= 4'd1;
      first_q      <= 1'b1;
      step_q       <= 1'b0;
      color0_q     <= 3'b111;
      color1_q     <= 3'b111;
      breath_en_q  <= 1'b0;
      breath_cnt_q <= 25'(BREATH_BASE);
    end else begin
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      presc_q      <= presc_d;
      dwell_q      <= dwell_d;
      spd_q        <= spd_d;
      first_q      <= 1'b0;
      step_q       <= step_d;
      color0_q     <= color0_d;
      color1_q     <= color1_d;
      breath_en_q  <= breath_en_d;
      breath_cnt_q <= breath_cnt_d;
    end
  end

  // Next state: a key pulse overrides any coincident step and clears the step timers
  always_comb begin
    mode_d  = mode_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    presc_d = '0;
    dwell_d = 16'd0;
    spd_d   = spd_q;
    step_d  = 1'b0;
    if (key_pulse) begin
      mode_d  = next_mode(mode_q);
      phase_d = 1'b0;
      spd_d   = spd_eff;
    end else if (running) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      dwell_d = step ? 16'd0 : (tick ? dwell_q + 16'd1 : dwell_q);
      if (step) begin
        step_d = 1'b1;
        spd_d  = spd_eff;
        if (mode_q == M_ALT) begin
          phase_d = ~phase_q;
          if (phase_q) idx_d = idx_next;
        end else begin
          idx_d = idx_next;
        end
      end
    end
    if (first_q) spd_d = spd_eff;
  end

  // Output decode from next state so colours land on the same edge as the mode/idx update
  always_comb begin
    color0_d     = 3'b111;
    color1_d     = 3'b111;
    breath_en_d  = 1'b0;
    breath_cnt_d = 25'(BREATH_BASE) * 25'(spd_d);
    case (mode_d)
      M_SOLID, M_CYCLE: begin
        color0_d = palette(idx_d);
        color1_d = palette(idx_d);
      end
      M_BREATH: breath_en_d = 1'b1;
      M_ALT: begin
        if (phase_d) color1_d = palette(idx_d);
        else         color0_d = palette(idx_d);
      end
      default: ;
    endcase
  end

  assign mode           = mode_q;
  assign color0         = color0_q;
  assign color1         = color1_q;
  assign breath_en      = breath_en_q;
  assign breath_cnt_num = breath_cnt_q;
  assign step_pulse     = step_q;

endmodule

// File: tb/tb_rgb_mode_sequencer.sv
// tb/tb_rgb_mode_sequencer.sv - directed vector bench for rgb_mode_sequencer
module tb_rgb_mode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_pulse;
  logic [3:0]  speed;
  logic [2:0]  mode, color0, color1;
  logic        breath_en;
  logic [24:0] breath_cnt_num;
  logic        step_pulse;

  int errors = 0;
  int checks = 0;

  rgb_mode_sequencer #(.TICK_DIV(4), .DWELL_UNIT(2), .BREATH_BASE(1000)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .speed(speed),
    .mode(mode), .color0(color0), .color1(color1), .breath_en(breath_en),
    .breath_cnt_num(breath_cnt_num), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        key;
    logic [3:0]  spd;
    logic [2:0]  m;
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic        ben;
    logic [24:0] bc;
  } vec_t;

  vec_t tbl[5];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mode"}, 32'(mode), 32'd0);
    check({tag, " color0"}, 32'(color0), 32'b111);
    check({tag, " color1"}, 32'(color1), 32'b111);
    check({tag, " breath_en"}, 32'(breath_en), 32'd0);
    check({tag, " breath_cnt"}, 32'(breath_cnt_num), 32'd1000);
    check({tag, " step_pulse"}, 32'(step_pulse), 32'd0);
  endtask

  // Step expected exactly n edges from now; also proves the previous pulse was one cycle wide
  task automatic expect_step(input string name, input int n, input logic [2:0] c0, input logic [2:0] c1);
    int early;
    early = 0;
    for (int i = 0; i < n - 1; i++) begin
      cyc(1);
      if (step_pulse !== 1'b0) early++;
    end
    check({name, " no early step"}, 32'(early), 32'd0);
    cyc(1);
    check({name, " step_pulse"}, 32'(step_pulse), 32'd1);
    check({name, " color0"}, 32'(color0), 32'(c0));
    check({name, " color1"}, 32'(color1), 32'(c1));
  endtask

  task automatic key_press();
    key_pulse = 1'b1;
    cyc(1);
    key_pulse = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [2:0] exp_m[4];
    logic [2:0] exp_c[4];

    tbl[0] = '{key: 1'b1, spd: 4'd3, m: 3'd1, c0: 3'b110, c1: 3'b110, ben: 1'b0, bc: 25'd3000};
    tbl[1] = '{key: 1'b0, spd: 4'd3, m: 3'd1, c0: 3'b110, c1: 3'b110, ben: 1'b0, bc: 25'd3000};
    tbl[2] = '{key: 1'b1, spd: 4'd3, m: 3'd2, c0: 3'b111, c1: 3'b111, ben: 1'b1, bc: 25'd3000};
    tbl[3] = '{key: 1'b0, spd: 4'd0, m: 3'd2, c0: 3'b111, c1: 3'b111, ben: 1'b1, bc: 25'd3000};
    tbl[4] = '{key: 1'b1, spd: 4'd0, m: 3'd3, c0: 3'b110, c1: 3'b110, ben: 1'b0, bc: 25'd1000};

    rst = 1'b0;
    key_pulse = 1'b0;
    speed = 4'd0;
    cyc(3);
    check_reset_outputs("reset");
    rst = 1'b1;

    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (step_pulse !== 1'b0) cnt++;
    end
    check("idle step count", 32'(cnt), 32'd0);
    check_reset_outputs("idle");

    for (int i = 0; i < 5; i++) begin
      key_pulse = tbl[i].key;
      speed = tbl[i].spd;
      cyc(1);
      check($sformatf("vec%0d mode", i), 32'(mode), 32'(tbl[i].m));
      check($sformatf("vec%0d color0", i), 32'(color0), 32'(tbl[i].c0));
      check($sformatf("vec%0d color1", i), 32'(color1), 32'(tbl[i].c1));
      check($sformatf("vec%0d breath_en", i), 32'(breath_en), 32'(tbl[i].ben));
      check($sformatf("vec%0d breath_cnt", i), 32'(breath_cnt_num), 32'(tbl[i].bc));
    end
    key_pulse = 1'b0;

    expect_step("cyc1", 8, 3'b100, 3'b100);
    expect_step("cyc2", 8, 3'b101, 3'b101);
    expect_step("cyc3", 8, 3'b001, 3'b001);
    expect_step("cyc4", 8, 3'b011, 3'b011);
    expect_step("cyc5", 8, 3'b010, 3'b010);
    expect_step("cyc6", 8, 3'b110, 3'b110);

    speed = 4'd1;
    key_press();
    check("alt entry mode", 32'(mode), 32'd4);
    check("alt entry color0", 32'(color0), 32'b110);
    check("alt entry color1", 32'(color1), 32'b111);
    expect_step("alt p1", 8, 3'b111, 3'b110);
    expect_step("alt p0", 8, 3'b100, 3'b111);

    exp_m[0] = 3'd0; exp_c[0] = 3'b111;
    exp_m[1] = 3'd1; exp_c[1] = 3'b100;
    exp_m[2] = 3'd2; exp_c[2] = 3'b111;
    exp_m[3] = 3'd3; exp_c[3] = 3'b100;
    for (int k = 0; k < 4; k++) begin
      key_pulse = 1'b1;
      cyc(1);
      check($sformatf("burst%0d mode", k), 32'(mode), 32'(exp_m[k]));
      check($sformatf("burst%0d color0", k), 32'(color0), 32'(exp_c[k]));
    end
    key_pulse = 1'b0;

    cyc(6);
    key_pulse = 1'b1;
    cyc(1);
    key_pulse = 1'b0;
    check("coinc mode", 32'(mode), 32'd4);
    check("coinc color0", 32'(color0), 32'b100);
    check("coinc color1", 32'(color1), 32'b111);
    check("coinc step_pulse", 32'(step_pulse), 32'd0);
    expect_step("coinc next", 8, 3'b111, 3'b100);

    key_press();
    check("alt exit mode", 32'(mode), 32'd0);
    key_pulse = 1'b1;
    cyc(3);
    key_pulse = 1'b0;
    check("recycle mode", 32'(mode), 32'd3);
    check("recycle color0", 32'(color0), 32'b100);
    expect_step("pre-rst a", 8, 3'b101, 3'b101);
    expect_step("pre-rst b", 8, 3'b001, 3'b001);

    cyc(3);
    rst = 1'b0;
    #1;
    check_reset_outputs("async rst");
    cyc(2);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (step_pulse !== 1'b0) cnt++;
    end
    check("post-rst step count", 32'(cnt), 32'd0);
    check_reset_outputs("post-rst");

    key_pulse = 1'b1;
    cyc(3);
    key_pulse = 1'b0;
    check("spd cycle mode", 32'(mode), 32'd3);
    check("spd cycle color0", 32'(color0), 32'b110);
    speed = 4'd2;
    expect_step("spd old dwell", 8, 3'b100, 3'b100);
    expect_step("spd new dwell", 16, 3'b101, 3'b101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
